fetch_queue: RTL and testbench

- Instruction fetch queue between the realigner (upstream) and decode (downstream).
- Issues sequential fetch requests, tracks the fetch PC and advances it by 2 for compressed or 4 for uncompressed instructions.
- Buffers each returned instruction with its PC and compressed flag in a DEPTH-entry FIFO.
- Handles redirects (branch, trap) by killing the in-flight request and flushing the queue. Handles fence.i by draining and then pulsing an icache flush.

---
 rtl/fetch_queue_pkg.sv | 30 +++
 rtl/fetch_queue_if.sv | 41 ++++
 rtl/fetch_queue_fifo.sv | 85 ++++++++
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch queue types and helpers
//
// Purpose: FSM state enum, queue entry layout and compressed-instruction
//          detect shared by the fetch queue, its FIFO and the bench.
// Ports:   none (package).
package fetch_queue_pkg;

   localparam int unsigned FQ_XLEN = 32;

   // Low two bits of every 32-bit instruction; anything else is a 16-bit one.
   localparam logic [1:0] FQ_UNCOMP_LSB = 2'b11;

   typedef enum logic [1:0] {
      FQ_BOOT  = 2'd0,
      FQ_RUN   = 2'd1,
      FQ_DRAIN = 2'd2,
      FQ_FLUSH = 2'd3
   } fq_state_e;

   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [31:0]        instr;
      logic               comp;
   } type_fq_entry_s;

   function automatic logic is_compressed(input logic [31:0] instr);
      return instr[1:0] != FQ_UNCOMP_LSB;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue control, realigner and decode signal bundle
//
// Purpose: groups every non-clock/reset signal of fetch_queue.
// Ports:   control  redirect_i, redirect_pc_i, fence_i_i, flush_done_i, icache_flush_o
//          fetch    fetch_req_o, fetch_addr_o, fetch_kill_o, fetch_ack_i, fetch_rdata_i
//          decode   instr_valid_o, instr_o, instr_pc_o, instr_comp_o, instr_ready_i
//          master = fetch queue side, slave = surrounding pipeline side.
interface fetch_queue_if #(
   parameter int unsigned XLEN = 32
);
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            fence_i_i;
   logic            flush_done_i;
   logic            fetch_req_o;
   logic [XLEN-1:0] fetch_addr_o;
   logic            fetch_kill_o;
   logic            icache_flush_o;
   logic            fetch_ack_i;
   logic [31:0]     fetch_rdata_i;
   logic            instr_valid_o;
   logic [31:0]     instr_o;
   logic [XLEN-1:0] instr_pc_o;
   logic            instr_comp_o;
   logic            instr_ready_i;

   modport master (
      input  redirect_i, redirect_pc_i, fence_i_i, flush_done_i,
      input  fetch_ack_i, fetch_rdata_i, instr_ready_i,
      output fetch_req_o, fetch_addr_o, fetch_kill_o, icache_flush_o,
      output instr_valid_o, instr_o, instr_pc_o, instr_comp_o
   );

   modport slave (
      output redirect_i, redirect_pc_i, fence_i_i, flush_done_i,
      output fetch_ack_i, fetch_rdata_i, instr_ready_i,
      input  fetch_req_o, fetch_addr_o, fetch_kill_o, icache_flush_o,
      input  instr_valid_o, instr_o, instr_pc_o, instr_comp_o
   );

endinterface

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - fetch queue entry storage with synchronous flush
//
// Purpose: DEPTH-entry FIFO of fetched instructions, zero-latency head read.
// Ports:   clk, rst_n        clock, synchronous active-low reset
//          flush_i           clear pointers and count (storage contents kept)
//          push_i/push_data_i write an entry at the tail
//          pop_i             retire the head
//          head_o            entry at the head, read straight from storage
//          full_o/empty_o    occupancy flags
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush_i,
   input  logic           push_i,
   input  type_fq_entry_s push_data_i,
   input  logic           pop_i,
   output type_fq_entry_s head_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   type_fq_entry_s   mem_q [DEPTH];
   type_fq_entry_s   mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // A pop frees the slot the same cycle, so a full queue may still accept a push.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between realigner and decode
//
// Purpose: issues sequential fetches, tracks the fetch PC (+2/+4), buffers
//          returned instructions, handles redirects and fence.i drain/flush.
// Ports:   clk, rst_n  clock, synchronous active-low reset
//          bus         fetch_queue_if.master (control, realigner, decode)
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned     XLEN     = FQ_XLEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic           clk,
   input  logic           rst_n,
   fetch_queue_if.master  bus
);

   fq_state_e       state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            icache_flush_q, icache_flush_d;

   logic            redirect_act;
   logic [XLEN-1:0] redirect_pc;
   logic            fetch_req;
   logic            ack_take;
   logic            pop;
   logic            comp;
   logic            full, empty;
   type_fq_entry_s  push_entry, head;

   assign redirect_pc  = {bus.redirect_pc_i[XLEN-1:1], 1'b0};
   assign redirect_act = bus.redirect_i && (state_q != FQ_BOOT);
   assign comp         = is_compressed(bus.fetch_rdata_i);

   // Request stays up until acked: count only grows on ack, so full cannot rise early.
   always_comb begin
      fetch_req = 1'b0;
      case (state_q)
         FQ_RUN:   fetch_req = !full;
         FQ_DRAIN: fetch_req = 1'b1;
         default:  fetch_req = 1'b0;
      endcase
   end

   // Acks without a request, or in a redirect cycle, are dropped.
   assign ack_take   = bus.fetch_ack_i && fetch_req && !redirect_act;
   assign pop        = !empty && bus.instr_ready_i;
   assign push_entry = '{pc: fetch_pc_q, instr: bus.fetch_rdata_i, comp: comp};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (ack_take) begin
         fetch_pc_d = fetch_pc_q + (comp ? XLEN'(2) : XLEN'(4));
      end
      case (state_q)
         FQ_BOOT: state_d = FQ_RUN;
         FQ_RUN: begin
            if (bus.fence_i_i) begin
               state_d = (fetch_req && !bus.fetch_ack_i) ? FQ_DRAIN : FQ_FLUSH;
            end
         end
         FQ_DRAIN: begin
            if (ack_take) begin
               state_d = FQ_FLUSH;
            end
         end
         FQ_FLUSH: begin
            if (bus.flush_done_i) begin
               state_d = FQ_RUN;
            end
         end
         default: state_d = FQ_BOOT;
      endcase
      if (redirect_act) begin
         state_d    = FQ_RUN;
         fetch_pc_d = redirect_pc;
      end
      // Registered so the pulse covers the first FLUSH cycle and survives a redirect there.
      icache_flush_d = (state_d == FQ_FLUSH) && (state_q != FQ_FLUSH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= FQ_BOOT;
         fetch_pc_q     <= RESET_PC;
         icache_flush_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         fetch_pc_q     <= fetch_pc_d;
         icache_flush_q <= icache_flush_d;
      end
   end

   fetch_queue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect_act),
      .push_i      (ack_take),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (full),
      .empty_o     (empty)
   );

   assign bus.fetch_req_o    = fetch_req;
   assign bus.fetch_addr_o   = redirect_act ? redirect_pc : fetch_pc_q;
   assign bus.fetch_kill_o   = redirect_act;
   assign bus.icache_flush_o = icache_flush_q;
   assign bus.instr_valid_o  = !empty;
   assign bus.instr_o        = head.instr;
   assign bus.instr_pc_o     = head.pc;
   assign bus.instr_comp_o   = head.comp;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_FLUSH = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_queue_if #(.XLEN(32)) bus();

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        red;
      logic [31:0] rpc;
      logic        fence;
      logic        done;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_kill;
      logic        e_flush;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_comp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic red, input logic [31:0] rpc, input logic fence, input logic done,
                      input logic ack, input logic [31:0] rdata, input logic rdy,
                      input logic e_req, input logic [31:0] e_addr, input logic e_kill,
                      input logic e_flush, input logic e_valid, input logic [31:0] e_pc,
                      input logic [31:0] e_instr, input logic e_comp);
      vec_t v;
      v = '{red, rpc, fence, done, ack, rdata, rdy,
            e_req, e_addr, e_kill, e_flush, e_valid, e_pc, e_instr, e_comp};
      vecs.push_back(v);
   endtask

   task automatic drive(input logic red, input logic [31:0] rpc, input logic fence, input logic done,
                        input logic ack, input logic [31:0] rdata, input logic rdy);
      bus.redirect_i    = red;
      bus.redirect_pc_i = rpc;
      bus.fence_i_i     = fence;
      bus.flush_done_i  = done;
      bus.fetch_ack_i   = ack;
      bus.fetch_rdata_i = rdata;
      bus.instr_ready_i = rdy;
   endtask

   // Reference model state: an ordinary queue of entries plus fetch PC and mode.
   type_fq_entry_s q[$];
   logic [31:0]    m_pc;
   int             m_mode;
   logic           m_pulse;

   logic        e_req, redir, take, popd, cmp;
   logic [31:0] e_addr, rd, rp;
   int          old_mode;

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",   32'(bus.fetch_req_o),    0);
      check("rst_addr",  bus.fetch_addr_o,        RESET_PC);
      check("rst_kill",  32'(bus.fetch_kill_o),   0);
      check("rst_flush", 32'(bus.icache_flush_o), 0);
      check("rst_valid", 32'(bus.instr_valid_o),  0);
      check("rst_instr", bus.instr_o,             0);
      check("rst_pc",    bus.instr_pc_o,          0);
      check("rst_comp",  32'(bus.instr_comp_o),   0);
      rst_n = 1'b1;

      //  red rpc            fn dn ack rdata          rdy  req addr           kil fl val pc             instr          comp
      add(0, 0,              0, 0, 0, 0,              1,   0, 32'h8000_0000, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 1, 32'h13,         1,   1, 32'h8000_0000, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 1, 32'h13,         1,   1, 32'h8000_0004, 0, 0, 1, 32'h8000_0000, 32'h13,        0);
      add(0, 0,              0, 0, 1, 32'h13,         1,   1, 32'h8000_0008, 0, 0, 1, 32'h8000_0004, 32'h13,        0);
      add(0, 0,              0, 0, 0, 0,              1,   1, 32'h8000_000C, 0, 0, 1, 32'h8000_0008, 32'h13,        0);
      add(0, 0,              0, 0, 1, 32'h4501,       1,   1, 32'h8000_000C, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 1, 32'h00A0_0093,  1,   1, 32'h8000_000E, 0, 0, 1, 32'h8000_000C, 32'h4501,      1);
      add(0, 0,              0, 0, 0, 0,              1,   1, 32'h8000_0012, 0, 0, 1, 32'h8000_000E, 32'h00A0_0093, 0);
      add(0, 0,              0, 0, 1, 32'h13,         0,   1, 32'h8000_0012, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 1, 32'h13,         0,   1, 32'h8000_0016, 0, 0, 1, 32'h8000_0012, 32'h13,        0);
      add(0, 0,              0, 0, 1, 32'h13,         0,   1, 32'h8000_001A, 0, 0, 1, 32'h8000_0012, 32'h13,        0);
      add(0, 0,              0, 0, 1, 32'h13,         0,   1, 32'h8000_001E, 0, 0, 1, 32'h8000_0012, 32'h13,        0);
      add(0, 0,              0, 0, 1, 32'h13,         0,   0, 32'h8000_0022, 0, 0, 1, 32'h8000_0012, 32'h13,        0);
      add(0, 0,              0, 0, 0, 0,              1,   0, 32'h8000_0022, 0, 0, 1, 32'h8000_0012, 32'h13,        0);
      add(0, 0,              0, 0, 0, 0,              0,   1, 32'h8000_0022, 0, 0, 1, 32'h8000_0016, 32'h13,        0);
      add(1, 32'h8000_1000,  0, 0, 1, 32'h13,         0,   1, 32'h8000_1000, 1, 0, 1, 32'h8000_0016, 32'h13,        0);
      add(0, 0,              0, 0, 0, 0,              1,   1, 32'h8000_1000, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 1, 32'h13,         1,   1, 32'h8000_1000, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 0, 0,              1,   1, 32'h8000_1004, 0, 0, 1, 32'h8000_1000, 32'h13,        0);
      add(0, 0,              1, 0, 0, 0,              1,   1, 32'h8000_1004, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 0, 0,              1,   1, 32'h8000_1004, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 1, 32'h13,         1,   1, 32'h8000_1004, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 0, 0,              1,   0, 32'h8000_1008, 0, 1, 1, 32'h8000_1004, 32'h13,        0);
      add(0, 0,              0, 0, 0, 0,              1,   0, 32'h8000_1008, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 1, 0, 0,              1,   0, 32'h8000_1008, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 0, 0,              1,   1, 32'h8000_1008, 0, 0, 0, 0,              0,             0);
      add(1, 32'hFFFF_FFFD,  0, 0, 0, 0,              1,   1, 32'hFFFF_FFFC, 1, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 1, 32'h13,         1,   1, 32'hFFFF_FFFC, 0, 0, 0, 0,              0,             0);
      add(0, 0,              0, 0, 0, 0,              1,   1, 32'h0000_0000, 0, 0, 1, 32'hFFFF_FFFC, 32'h13,        0);
      add(0, 0,              1, 0, 1, 32'h4501,       1,   1, 32'h0000_0000, 0, 0, 0, 0,              0,             0);
      add(1, 32'h8000_2000,  0, 0, 0, 0,              0,   0, 32'h8000_2000, 1, 1, 1, 32'h0000_0000, 32'h4501,      1);
      add(0, 0,              0, 0, 0, 0,              1,   1, 32'h8000_2000, 0, 0, 0, 0,              0,             0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].red, vecs[i].rpc, vecs[i].fence, vecs[i].done,
               vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
         @(negedge clk);
         check($sformatf("v%0d_req", i),   32'(bus.fetch_req_o),    32'(vecs[i].e_req));
         check($sformatf("v%0d_addr", i),  bus.fetch_addr_o,        vecs[i].e_addr);
         check($sformatf("v%0d_kill", i),  32'(bus.fetch_kill_o),   32'(vecs[i].e_kill));
         check($sformatf("v%0d_flush", i), 32'(bus.icache_flush_o), 32'(vecs[i].e_flush));
         check($sformatf("v%0d_valid", i), 32'(bus.instr_valid_o),  32'(vecs[i].e_valid));
         if (vecs[i].e_valid) begin
            check($sformatf("v%0d_hpc", i),   bus.instr_pc_o,        vecs[i].e_pc);
            check($sformatf("v%0d_hins", i),  bus.instr_o,           vecs[i].e_instr);
            check($sformatf("v%0d_hcomp", i), 32'(bus.instr_comp_o), 32'(vecs[i].e_comp));
         end
         @(posedge clk);
         #1;
      end

      // Randomized traffic against the queue-based model.
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      q.delete();
      m_pc    = RESET_PC;
      m_mode  = M_BOOT;
      m_pulse = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rd = $urandom;
         if ($urandom_range(1) == 1) rd[1:0] = 2'b11;
         rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         drive($urandom_range(39) == 0, rp, $urandom_range(29) == 0, $urandom_range(3) == 0,
               $urandom_range(1) == 1, rd, $urandom_range(2) != 0);
         @(negedge clk);
         e_req  = (m_mode == M_RUN) ? (q.size() != DEPTH) : (m_mode == M_DRAIN);
         redir  = bus.redirect_i && (m_mode != M_BOOT);
         e_addr = redir ? (bus.redirect_pc_i & ~32'd1) : m_pc;
         check("rnd_req",   32'(bus.fetch_req_o),    32'(e_req));
         check("rnd_addr",  bus.fetch_addr_o,        e_addr);
         check("rnd_kill",  32'(bus.fetch_kill_o),   32'(redir));
         check("rnd_flush", 32'(bus.icache_flush_o), 32'(m_pulse));
         check("rnd_valid", 32'(bus.instr_valid_o),  32'(q.size() != 0));
         if (q.size() != 0) begin
            check("rnd_hpc",   bus.instr_pc_o,        q[0].pc);
            check("rnd_hins",  bus.instr_o,           q[0].instr);
            check("rnd_hcomp", 32'(bus.instr_comp_o), 32'(q[0].comp));
         end
         @(posedge clk);
         #1;
         take = bus.fetch_ack_i && e_req && !redir;
         popd = (q.size() != 0) && bus.instr_ready_i;
         cmp  = (bus.fetch_rdata_i[1:0] != 2'b11);
         if (redir) begin
            q.delete();
            m_pc    = bus.redirect_pc_i & ~32'd1;
            m_mode  = M_RUN;
            m_pulse = 1'b0;
         end else begin
            old_mode = m_mode;
            if (popd) void'(q.pop_front());
            if (take) begin
               q.push_back('{pc: m_pc, instr: bus.fetch_rdata_i, comp: cmp});
               m_pc = m_pc + (cmp ? 32'd2 : 32'd4);
            end
            case (m_mode)
               M_BOOT:  m_mode = M_RUN;
               M_RUN:   if (bus.fence_i_i) m_mode = (e_req && !bus.fetch_ack_i) ? M_DRAIN : M_FLUSH;
               M_DRAIN: if (take) m_mode = M_FLUSH;
               default: if (bus.flush_done_i) m_mode = M_RUN;
            endcase
            m_pulse = (m_mode == M_FLUSH) && (old_mode != M_FLUSH);
         end
      end

      // Reset in the middle of an acked request.
      drive(0, 0, 0, 0, 1, 32'h13, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_req",   32'(bus.fetch_req_o),    0);
      check("mid_rst_kill",  32'(bus.fetch_kill_o),   0);
      check("mid_rst_addr",  bus.fetch_addr_o,        RESET_PC);
      check("mid_rst_valid", 32'(bus.instr_valid_o),  0);
      check("mid_rst_flush", 32'(bus.icache_flush_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
